operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Upstream neighbour of the 8-bit ALU. Holds the architectural register file and a per-register pending scoreboard.
- Accepts decoded instructions over a valid/ready handshake and reads the two source operands, with an optional immediate for B.
- Issues A, B and OP to the ALU through a one-entry output register.
- Takes the ALU result back through a writeback port.

Parameters:
- W, 8, data width of registers and operands
- Ops, 3, opcode width; matches the ALU OP port
- NREG, 8, number of registers; address width RA = $clog2(NREG)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts the instruction this cycle
- in_op  input  Ops  ALU opcode (000 add, 001 shr, 010 shl, 011 xor)
- in_rd  input  RA  destination register
- in_rs  input  RA  source register for A
- in_rt  input  RA  source register for B
- in_imm_sel  input  1  1: B = in_imm; in_rt ignored for hazards
- in_imm  input  W  immediate operand
- out_valid  output  1  A/B/OP valid toward ALU
- out_ready  input  1  downstream consumes the output this cycle
- out_A  output  W  operand A
- out_B  output  W  operand B
- out_OP  output  Ops  opcode
- out_rd  output  RA  destination, carried to writeback
- wb_en  input  1  write ALU result
- wb_addr  input  RA  writeback register
- wb_data  input  W  writeback value

Behaviour:
- Reset (async, immediate):
  - All registers = 0 and all pending bits = 0.
  - out_valid = 0; out_A, out_B, out_OP and out_rd = 0.
- Register 0 is hardwired:
  - It always reads 0.
  - Writes to it are ignored.
  - It is never pending.
- Writeback:
  - At the clock edge with wb_en=1 and wb_addr≠0, reg[wb_addr] <= wb_data and pending[wb_addr] <= 0.
- Hazard: a source is busy when pending[src]=1. The hazard is cleared in the same cycle if wb_en=1 and wb_addr=src. Otherwise it holds.
  - rt is checked only when in_imm_sel=0.
- in_ready = (!out_valid || out_ready) && !hazard.
  - This is combinational.
  - It is permitted to depend on in_valid and the in_* fields through the hazard check.
- Accept (in_valid && in_ready):
  - The next edge latches out_A, out_B, out_OP and out_rd, and sets out_valid=1.
  - The same edge sets pending[in_rd]=1 when in_rd≠0.
- Latency: one cycle from accept to out_valid.
- Output hold: while out_valid=1 and out_ready=0, all out_* stay stable.
- Consume without a new accept: out_valid <= 0 and the out_* data holds its last value.
- Back-to-back: a new accept on the same edge as a consume keeps out_valid=1 and takes the new data.
- Simultaneous writeback and issue to the same rd: the issue wins and the pending bit ends at 1.
- Reset mid-operation discards the in-flight output and clears every pending bit.

Optional Feature:
- Macro: OPERAND_FWD_EN
- Defined: when wb_en=1, wb_addr=src and src≠0, the operand value is wb_data in the same cycle (write-through bypass). The matching hazard is cleared in that cycle, so accept is allowed.
- Undefined: a source matching a pending register stalls until the cycle after the writeback edge. Operands are read from the array only, and the same-cycle hazard clear is removed.

Decomposition:
- Shared package cpu_pkg holds:
  - W and Ops defaults
  - opcode enum: OP_ADD=3'b000, OP_SHR=3'b001, OP_SHL=3'b010, OP_XOR=3'b011
  - reg address typedef
- Natural sub-module: reg_file.
  - NREG x W storage, two combinational read ports and one write port.
  - Async-reset clear and r0 hardwiring live here.
- The scoreboard, bypass and output register stay in the top module.

Test Plan:
- Reset:
  - Stimulus: assert reset mid-stream, then issue add r1=r0+imm 5.
  - Required: out_valid drops immediately. After reset release, out_A=0, out_B=5, out_OP=000, out_rd=1 one cycle after accept.
- Hazard stall:
  - Stimulus: issue r2=r1+r1, then xor r3=r2^r2 while r2 is pending.
  - Required: in_ready=0 until wb_en with wb_addr=2 and wb_data=0x3C. The xor then issues with out_A=out_B=0x3C. With OPERAND_FWD_EN, the issue happens in the writeback cycle; without it, one cycle later.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles with in_valid=1.
  - Required: out_* stable, in_ready=0. On out_ready=1, a back-to-back accept keeps out_valid=1.
- Register 0:
  - Stimulus: wb_en writes 0xFF to r0, then read r0.
  - Required: the read returns 0, and an instruction with rd=0 never causes a stall.
- Simultaneous issue and writeback:
  - Stimulus: issue with rd=4 on the same edge as wb_en, wb_addr=4.
  - Required: pending[4]=1 afterwards. A following read of r4 stalls until the next wb to r4.
- Shift operand:
  - Stimulus: shl with in_imm_sel=1, in_imm=3, rs=r5=0x11.
  - Required: out_A=0x11, out_B=0x03, out_OP=010.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, ALU opcodes and the
// register-address type used by the operand fetch stage and the ALU.
package cpu_pkg;
  localparam int DATA_W   = 8;   // default operand width
  localparam int OP_W     = 3;   // default ALU opcode width
  localparam int NREG_DEF = 8;   // default register count

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SHR = 3'b001,
    OP_SHL = 3'b010,
    OP_XOR = 3'b011
  } op_e;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
endpackage

// File: rtl/operand_fetch_stage_reg_file.sv
// reg_file: NREG x W architectural register file.
// Two combinational read ports, one write port.
// r0 is hardwired: it always reads 0 and writes to it are dropped.
// Ports:
//   clk, reset     - clock, asynchronous active-high clear of every register
//   ra0/ra1        - read addresses;  rd0/rd1 - read data
//   we/wa/wd       - write enable / address / data
module reg_file
  import cpu_pkg::*;
#(
  parameter int W    = DATA_W,
  parameter int NREG = NREG_DEF,
  parameter int RA   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RA-1:0] ra0,
  input  logic [RA-1:0] ra1,
  output logic [W-1:0]  rd0,
  output logic [W-1:0]  rd1,
  input  logic          we,
  input  logic [RA-1:0] wa,
  input  logic [W-1:0]  wd
);
  logic [W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd0 = (ra0 == '0) ? '0 : mem[ra0];
  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads the two source operands of a decoded
// instruction, tracks in-flight destinations in a pending scoreboard and
// issues A/B/OP to the ALU through a one-entry output register.
// Config macro: OPERAND_FWD_EN - same-cycle writeback bypass into the
//   operand read and hazard check. Undefined: operands come from the array
//   only, so a pending source waits until the cycle after its writeback.
// Ports:
//   clk, reset                   - clock, async active-high reset
//   in_valid/in_ready            - instruction handshake
//   in_op/in_rd/in_rs/in_rt      - opcode, destination, sources
//   in_imm_sel/in_imm            - select immediate for B
//   out_valid/out_ready          - ALU handshake
//   out_A/out_B/out_OP/out_rd    - issued operands, opcode, destination
//   wb_en/wb_addr/wb_data        - ALU result writeback
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int W    = DATA_W,
  parameter int Ops  = OP_W,
  parameter int NREG = NREG_DEF,
  parameter int RA   = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Ops-1:0] in_op,
  input  logic [RA-1:0]  in_rd,
  input  logic [RA-1:0]  in_rs,
  input  logic [RA-1:0]  in_rt,
  input  logic           in_imm_sel,
  input  logic [W-1:0]   in_imm,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_A,
  output logic [W-1:0]   out_B,
  output logic [Ops-1:0] out_OP,
  output logic [RA-1:0]  out_rd,
  input  logic           wb_en,
  input  logic [RA-1:0]  wb_addr,
  input  logic [W-1:0]   wb_data
);
  logic [W-1:0]    rf_a, rf_b, opa, opb;
  logic            hit_s, hit_t, busy_s, busy_t, hazard, accept;
  logic [NREG-1:0] pending, pending_nxt;

  reg_file #(.W(W), .NREG(NREG), .RA(RA)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra0   (in_rs),
    .ra1   (in_rt),
    .rd0   (rf_a),
    .rd1   (rf_b),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

`ifdef OPERAND_FWD_EN
  // A result landing this cycle both supplies the value and lifts the stall.
  assign hit_s = wb_en && (wb_addr == in_rs) && (in_rs != '0);
  assign hit_t = wb_en && (wb_addr == in_rt) && (in_rt != '0);
  assign opa   = hit_s ? wb_data : rf_a;
  assign opb   = hit_t ? wb_data : rf_b;
`else
  assign hit_s = 1'b0;
  assign hit_t = 1'b0;
  assign opa   = rf_a;
  assign opb   = rf_b;
`endif

  // pending[0] is never set, so r0 sources never stall.
  assign busy_s   = pending[in_rs] && !hit_s;
  assign busy_t   = !in_imm_sel && pending[in_rt] && !hit_t;
  assign hazard   = busy_s || busy_t;
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Writeback clears first, issue sets after: an issue to the same rd wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_en && wb_addr != '0) pending_nxt[wb_addr] = 1'b0;
    if (accept && in_rd != '0)  pending_nxt[in_rd]   = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  // One-entry output register; data holds after consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_A     <= '0;
      out_B     <= '0;
      out_OP    <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_A     <= opa;
      out_B     <= in_imm_sel ? in_imm : opb;
      out_OP    <= in_op;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage. Inputs change 1ns
// after the rising edge; combinational outputs are checked after a 1ns
// settle, registered outputs 1ns after the edge.
module tb_operand_fetch_stage;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_imm_sel;
  logic [2:0] in_op, in_rd, in_rs, in_rt;
  logic [7:0] in_imm;
  logic       out_valid, out_ready;
  logic [7:0] out_A, out_B;
  logic [2:0] out_OP, out_rd;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A),
    .out_B(out_B), .out_OP(out_OP), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, rd, rs, rt, input logic sel, input logic [7:0] imm);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_imm_sel = sel; in_imm = imm;
  endtask

  task automatic wb(input logic [2:0] a, input logic [7:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic quiet();
    in_valid = 1'b0; wb_en = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] a, b, input logic [2:0] op, rd);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".A"},     32'(out_A),     32'(a));
    check({tag, ".B"},     32'(out_B),     32'(b));
    check({tag, ".OP"},    32'(out_OP),    32'(op));
    check({tag, ".rd"},    32'(out_rd),    32'(rd));
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 0; in_op = 0; in_rd = 0; in_rs = 0; in_rt = 0;
    in_imm_sel = 0; in_imm = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    #1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.A",     32'(out_A),     32'd0);
    check("rst.rd",    32'(out_rd),    32'd0);
    tick(); tick();
    reset = 1'b0;

    // First issue, then reset while the output is in flight.
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h09);
    #1 check("pre.ready", 32'(in_ready), 32'd1);
    tick(); quiet();
    chk_out("pre", 8'h00, 8'h09, OP_ADD, 3'd1);
    reset = 1'b1;
    #1 check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.B", 32'(out_B), 32'd0);
    tick(); reset = 1'b0;

    // r1 pending was cleared by reset: reading r1 must not stall.
    issue(OP_ADD, 3'd0, 3'd1, 3'd1, 1'b0, 8'h00);
    #1 check("rst.pend_clr", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
    tick(); quiet();
    chk_out("rst_add", 8'h00, 8'h05, OP_ADD, 3'd1);

    // Consume with no new accept: valid drops, data holds.
    wb(3'd1, 8'h07);
    tick(); quiet();
    check("consume.valid", 32'(out_valid), 32'd0);
    check("consume.B",     32'(out_B),     32'd5);
    wb(3'd5, 8'h11);
    tick(); quiet();

    // Hazard: r2=r1+r1, then r3=r2^r2 stalls until writeback of r2.
    issue(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00);
    tick();
    chk_out("r2add", 8'h07, 8'h07, OP_ADD, 3'd2);
    issue(OP_XOR, 3'd3, 3'd2, 3'd2, 1'b0, 8'h00);
    #1 check("haz.stall0", 32'(in_ready), 32'd0);
    tick();
    check("haz.stall1", 32'(in_ready), 32'd0);
    wb(3'd2, 8'h3C);
`ifdef OPERAND_FWD_EN
    #1 check("haz.fwd_ready", 32'(in_ready), 32'd1);
    tick(); wb_en = 1'b0; in_valid = 1'b0;
`else
    #1 check("haz.wb_stall", 32'(in_ready), 32'd0);
    tick(); wb_en = 1'b0;
    #1 check("haz.ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
`endif
    chk_out("xor", 8'h3C, 8'h3C, OP_XOR, 3'd3);

    // Backpressure: out_ready=0 for 3 cycles with a ready-to-go instruction.
    out_ready = 1'b0;
    issue(OP_ADD, 3'd6, 3'd5, 3'd0, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp.ready", 32'(in_ready), 32'd0);
      tick();
      chk_out("bp.hold", 8'h3C, 8'h3C, OP_XOR, 3'd3);
    end
    out_ready = 1'b1;
    #1 check("bp.release", 32'(in_ready), 32'd1);
    tick(); quiet();
    chk_out("b2b", 8'h11, 8'h01, OP_ADD, 3'd6);

    // Register 0: write is ignored, reads 0, rd=0 never stalls.
    wb(3'd0, 8'hFF);
    tick(); quiet();
    issue(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    chk_out("r0read", 8'h00, 8'h00, OP_ADD, 3'd0);
    issue(OP_XOR, 3'd7, 3'd0, 3'd0, 1'b0, 8'h00);
    #1 check("r0.nostall", 32'(in_ready), 32'd1);
    tick(); quiet();

    // Simultaneous issue to r4 and writeback of r4: pending stays set.
    issue(OP_ADD, 3'd4, 3'd1, 3'd0, 1'b1, 8'h02);
    wb(3'd4, 8'h55);
    tick(); quiet();
    chk_out("sim", 8'h07, 8'h02, OP_ADD, 3'd4);
    issue(OP_SHR, 3'd3, 3'd4, 3'd0, 1'b1, 8'h01);
    #1 check("sim.stall", 32'(in_ready), 32'd0);
    tick();
    check("sim.stall2", 32'(in_ready), 32'd0);
    wb(3'd4, 8'h66);
`ifdef OPERAND_FWD_EN
    #1 check("sim.fwd_ready", 32'(in_ready), 32'd1);
    tick(); quiet();
`else
    #1 check("sim.wb_stall", 32'(in_ready), 32'd0);
    tick(); wb_en = 1'b0;
    #1 check("sim.ready", 32'(in_ready), 32'd1);
    tick(); quiet();
`endif
    chk_out("sim_rd", 8'h66, 8'h01, OP_SHR, 3'd3);

    // Shift with immediate B.
    issue(OP_SHL, 3'd1, 3'd5, 3'd7, 1'b1, 8'h03);
    #1 check("shl.ready", 32'(in_ready), 32'd1);
    tick(); quiet();
    chk_out("shl", 8'h11, 8'h03, OP_SHL, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
